// File: rtl/ram_read_streamer.sv
// Read-side burst sequencer for the dual-port RAM: issues reads, absorbs the
// one-cycle read latency and streams words out with valid/ready/last. Optional RD_STRIDE_EN.
module ram_read_streamer #(
    parameter int RAM_WIDTH  = 8,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    input  logic [ADDR_WIDTH:0]   length,
`ifdef RD_STRIDE_EN
    input  logic [ADDR_WIDTH-1:0] stride,
`endif
    output logic                  busy,
    output logic                  done,
    output logic                  rd_allow,
    output logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic [RAM_WIDTH-1:0]  rd_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [RAM_WIDTH-1:0]  out_data,
    output logic                  out_last
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_RUN   = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    localparam logic [ADDR_WIDTH:0] CNT_ONE = (ADDR_WIDTH+1)'(1);

    logic [1:0]            state;
    logic [ADDR_WIDTH-1:0] addr;
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] step;
    logic [ADDR_WIDTH:0]   issue_cnt;
    logic [ADDR_WIDTH:0]   beat_cnt;
    logic                  inflight;
    logic [RAM_WIDTH-1:0]  buf0;
    logic [RAM_WIDTH-1:0]  buf1;
    logic [1:0]            buf_cnt;
    logic [2:0]            occ;
    logic                  pop;
    logic                  issue;

`ifdef RD_STRIDE_EN
    logic [ADDR_WIDTH-1:0] stride_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            stride_q <= '0;
        else if (state == S_IDLE && start && length != '0)
            stride_q <= stride;
    end

    assign step = stride_q;
`else
    assign step = ADDR_WIDTH'(1);
`endif

    // Occupancy counts words already buffered plus the one in the RAM pipe,
    // so at most two words are ever owed to the buffer.
    always_comb begin
        pop   = out_valid & out_ready;
        occ   = {1'b0, buf_cnt} + {2'b00, inflight};
        issue = (state == S_RUN) && (issue_cnt != '0) && (occ < (3'd2 + {2'b00, pop}));
    end

    assign rd_allow  = issue;
    assign rd_addr   = issue ? addr : last_addr;
    assign busy      = (state != S_IDLE);
    assign out_valid = (buf_cnt != 2'd0);
    assign out_data  = buf0;
    assign out_last  = out_valid && (beat_cnt == CNT_ONE);
    assign done      = ((state == S_IDLE) && start && (length == '0)) ||
                       ((state == S_DRAIN) && pop && (beat_cnt == CNT_ONE));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            addr      <= '0;
            last_addr <= '0;
            issue_cnt <= '0;
            beat_cnt  <= '0;
            inflight  <= 1'b0;
        end else begin
            inflight <= issue;
            case (state)
                S_IDLE: begin
                    if (start && length != '0) begin
                        addr      <= base_addr;
                        issue_cnt <= length;
                        beat_cnt  <= length;
                        state     <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (issue) begin
                        addr      <= addr + step;
                        last_addr <= addr;
                        issue_cnt <= issue_cnt - CNT_ONE;
                        if (issue_cnt == CNT_ONE)
                            state <= S_DRAIN;
                    end
                    if (pop)
                        beat_cnt <= beat_cnt - CNT_ONE;
                end
                S_DRAIN: begin
                    if (pop) begin
                        beat_cnt <= beat_cnt - CNT_ONE;
                        if (beat_cnt == CNT_ONE)
                            state <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Two-entry FIFO: buf0 is always the head so out_data is purely registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf0    <= '0;
            buf1    <= '0;
            buf_cnt <= 2'd0;
        end else begin
            case ({inflight, pop})
                2'b01: begin
                    buf0    <= buf1;
                    buf_cnt <= buf_cnt - 2'd1;
                end
                2'b10: begin
                    if (buf_cnt == 2'd0)
                        buf0 <= rd_data;
                    else
                        buf1 <= rd_data;
                    buf_cnt <= buf_cnt + 2'd1;
                end
                2'b11: begin
                    if (buf_cnt == 2'd1) begin
                        buf0 <= rd_data;
                    end else begin
                        buf0 <= buf1;
                        buf1 <= rd_data;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/ram_read_streamer.md
Name: ram_read_streamer

Overview:
- Read-side sequencer for the team's dual-port RAM. Drives the RAM read port (enable and address) and absorbs the RAM's one-cycle registered read latency.
- Delivers a burst of consecutive words as a valid/ready stream with a last-beat flag, under full backpressure.
- Sits between a dual-port RAM buffer and downstream consumers, e.g. a spike/event packetiser.

Parameters:
RAM_WIDTH, 8, data word width in bits; must match the attached RAM
ADDR_WIDTH, 4, RAM address width; RAM depth is 2**ADDR_WIDTH

Ports:
clk  input  1  single clock; drives this block and the attached RAM read port
rst  input  1  asynchronous, active-high reset
start  input  1  burst request, sampled only in IDLE
base_addr  input  ADDR_WIDTH  first word address of the burst
length  input  ADDR_WIDTH+1  number of words, 0..2**ADDR_WIDTH
busy  output  1  high from accepted start until the done cycle, inclusive
done  output  1  one-cycle pulse when the final beat is accepted, or immediately when length=0
rd_allow  output  1  RAM read enable
rd_addr  output  ADDR_WIDTH  RAM read address
rd_data  input  RAM_WIDTH  RAM read data, valid the cycle after rd_allow
out_valid  output  1  stream data valid
out_ready  input  1  downstream ready
out_data  output  RAM_WIDTH  stream data
out_last  output  1  marks the final beat of the burst; qualified by out_valid

Behaviour:
- Reset (async, rst=1): state=IDLE. busy, done, rd_allow, out_valid and out_last are 0. rd_addr=0 and out_data=0. Buffer, counters and in-flight flag are cleared. rd_data arriving after reset is ignored.
- States: IDLE, RUN, DRAIN.
  - IDLE with start=1 and length!=0: latch base_addr into the address counter and length into the issue and beat counters; go to RUN; busy=1 next cycle.
  - IDLE with start=1 and length=0: done=1 for one cycle; busy stays 0; no RAM access.
  - start in RUN or DRAIN is ignored.
  - RUN: a read is issued (rd_allow=1, rd_addr=current address) when the issue count is nonzero and (buf_cnt + inflight - pop) < 2, where pop = out_valid & out_ready.
    - After each issue: the address increments modulo 2**ADDR_WIDTH (wrap from max to 0 is allowed) and the issue count decrements.
    - When the issue count reaches 0, go to DRAIN.
  - DRAIN: no reads are issued. Go to IDLE in the cycle the last beat is accepted; done=1 that cycle and busy drops the following cycle.
- In-flight flag: set the cycle after rd_allow. rd_data is pushed into the buffer on the clock edge that ends that cycle.
- Buffer: 2-entry FIFO. out_data and out_valid come straight from the head register, with no combinational path from rd_data to out_data. Push and pop in the same cycle are legal at any occupancy.
- Latency: start sampled at edge N. First rd_allow during cycle N+1. rd_data valid during N+2. out_valid=1 from N+3.
- Throughput: 1 word/cycle sustained while out_ready=1.
- Backpressure: while out_valid=1 and out_ready=0, out_data and out_last hold stable. The buffer never overflows; the issue rule guarantees this.
- out_last=1 exactly on the beat where the beat counter equals 1. The beat counter decrements on each pop.
- length=2**ADDR_WIDTH reads every word exactly once, starting at base_addr, with wrap.
- rd_allow is held 0 outside RUN. rd_addr holds its last value when idle.

Optional Feature:
- Macro: RD_STRIDE_EN
- When defined:
  - Adds input port stride, ADDR_WIDTH bits, latched on accepted start.
  - The address advances by the latched stride, modulo 2**ADDR_WIDTH, instead of by 1.
  - stride=0 re-reads base_addr length times.
- When undefined: the port is absent and the increment is fixed at 1.

Test Plan:
- Basic burst: base=3, length=4, out_ready=1 -> rd_addr 3,4,5,6 on consecutive cycles starting at N+1; out_valid from N+3 with words mem[3..6]; out_last on the 4th beat; done on that cycle; busy high N+1..N+6.
- Wrap-around (ADDR_WIDTH=4): base=14, length=4 -> addresses 14,15,0,1; data in that order.
- Backpressure: length=8 with out_ready toggled 1,0,0,1,... -> no lost or duplicated words; out_data stable while stalled; at most 2 reads ahead of consumption.
- length=0 and full depth:
  - length=0 -> single done pulse, busy=0, rd_allow never asserted.
  - length=16 -> 16 beats covering every address once.
- Busy start and mid-burst reset:
  - start pulsed during RUN with different base -> ignored.
  - rst asserted mid-burst -> all outputs 0 immediately; a new start afterwards produces a clean burst.
- RD_STRIDE_EN: base=1, stride=5, length=4 -> addresses 1,6,11,0.
